csr_trap_unit: RTL

Parametrised machine-mode CSR file and trap controller for the NPC core, succeeding the single-timer CSR block. It holds the M-mode CSRs and counters, takes ecall, external exceptions and three prioritised interrupt sources (software, timer, external), and supports direct and vectored mtvec. It sits beside ID/EX: it takes the decoded CSR operation and the current PC, and returns read data and a PC redirect for traps and mret.

---
 rtl/csr_trap_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file and trap controller
// Ports: clk, rst_n (sync, active-low); csr_op_i/csr_w_*/csr_r_* decoded CSR access;
// csr_pc_i current PC; exc_valid_i/exc_cause_i pipeline exception; retire_i retire pulse;
// irq_msip_i/irq_mtip_i/irq_meip_i level interrupts; csr_reg_write_o, csr_r_data_o,
// csr_illegal_o read side; trap_o, redirect_o, redirect_pc_o control-flow redirect.
module csr_trap_unit #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST  = 64'ha00001800,
  parameter bit              VECTORED_EN  = 1'b1,
  parameter bit              HAS_COUNTERS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_w_addr_i,
  input  logic            csr_wen_i,
  input  logic [XLEN-1:0] csr_w_data_i,
  input  logic [11:0]     csr_r_addr_i,
  input  logic            csr_ren_i,
  input  logic [XLEN-1:0] csr_pc_i,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic            retire_i,
  input  logic            irq_msip_i,
  input  logic            irq_mtip_i,
  input  logic            irq_meip_i,
  output logic            csr_reg_write_o,
  output logic [XLEN-1:0] csr_r_data_o,
  output logic            csr_illegal_o,
  output logic            trap_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  localparam logic [1:0] OP_RW    = 2'd1;
  localparam logic [1:0] OP_ECALL = 2'd2;
  localparam logic [1:0] OP_MRET  = 2'd3;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [XLEN-1:0] mcycle_q, minstret_q;
  logic [XLEN-1:0] mip, irq_bits, rd_val, tvec_base;
  logic            exc_take, mret_take, irq_take, wr_take, trap;
  logic [3:0]      irq_cause, trap_cause;

  function automatic logic addr_legal(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MIP: return 1'b1;
      A_MCYCLE, A_MINSTRET: return HAS_COUNTERS;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    mip     = '0;
    mip[3]  = irq_msip_i;
    mip[7]  = irq_mtip_i;
    mip[11] = irq_meip_i;
  end

  always_comb begin
    rd_val = '0;
    case (csr_r_addr_i)
      A_MSTATUS:  rd_val = mstatus_q;
      A_MIE:      rd_val = mie_q;
      A_MTVEC:    rd_val = mtvec_q;
      A_MSCRATCH: rd_val = mscratch_q;
      A_MEPC:     rd_val = mepc_q;
      A_MCAUSE:   rd_val = mcause_q;
      A_MIP:      rd_val = mip;
      A_MCYCLE:   rd_val = mcycle_q;
      A_MINSTRET: rd_val = minstret_q;
      default:    rd_val = '0;
    endcase
  end

  // Event arbitration: exception > MRET > interrupt > RW write; losers are dropped whole.
  assign exc_take  = (csr_op_i == OP_ECALL) || exc_valid_i;
  assign mret_take = !exc_take && (csr_op_i == OP_MRET);
  assign irq_bits  = mie_q & mip;
  assign irq_take  = mstatus_q[3] && (|irq_bits) && !exc_take && !mret_take;
  assign wr_take   = (csr_op_i == OP_RW) && csr_wen_i && !exc_take && !mret_take && !irq_take;
  assign trap      = exc_take || irq_take;

  always_comb begin
    irq_cause = 4'd7;
    if (irq_bits[11])     irq_cause = 4'd11;
    else if (irq_bits[3]) irq_cause = 4'd3;
  end

  always_comb begin
    trap_cause = irq_cause;
    if (exc_take) trap_cause = (csr_op_i == OP_ECALL) ? 4'd11 : exc_cause_i;
  end

  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    redirect_pc_o = '0;
    if (mret_take) begin
      redirect_pc_o = mepc_q;
    end else if (trap) begin
      redirect_pc_o = tvec_base;
      // Only interrupts use the vector table; exceptions always land on the base.
      if (irq_take && mtvec_q[1:0] == 2'b01)
        redirect_pc_o = tvec_base + {{(XLEN-6){1'b0}}, trap_cause, 2'b00};
    end
  end

  assign trap_o          = trap;
  assign redirect_o      = trap || mret_take;
  assign csr_reg_write_o = csr_ren_i;
  assign csr_r_data_o    = (csr_ren_i && addr_legal(csr_r_addr_i)) ? rd_val : '0;
  assign csr_illegal_o   = (csr_ren_i && !addr_legal(csr_r_addr_i)) ||
                           (csr_wen_i && (csr_op_i == OP_RW) && !addr_legal(csr_w_addr_i));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      // Increments first so a same-cycle CSR write below overrides them.
      if (HAS_COUNTERS) begin
        mcycle_q <= mcycle_q + 1'b1;
        if (retire_i) minstret_q <= minstret_q + 1'b1;
      end
      if (trap) begin
        mepc_q             <= csr_pc_i & ~XLEN'(1);
        mcause_q           <= {irq_take, {(XLEN-5){1'b0}}, trap_cause};
        mstatus_q[7]       <= mstatus_q[3];
        mstatus_q[3]       <= 1'b0;
        mstatus_q[12:11]   <= 2'b11;
      end else if (mret_take) begin
        mstatus_q[3]       <= mstatus_q[7];
        mstatus_q[7]       <= 1'b1;
        mstatus_q[12:11]   <= 2'b11;
      end else if (wr_take) begin
        case (csr_w_addr_i)
          A_MSTATUS:  mstatus_q  <= csr_w_data_i;
          A_MIE:      mie_q      <= csr_w_data_i;
          A_MTVEC:    mtvec_q    <= {csr_w_data_i[XLEN-1:2],
                                     (VECTORED_EN && csr_w_data_i[1:0] == 2'b01) ? 2'b01 : 2'b00};
          A_MSCRATCH: mscratch_q <= csr_w_data_i;
          A_MEPC:     mepc_q     <= csr_w_data_i & ~XLEN'(1);
          A_MCAUSE:   mcause_q   <= csr_w_data_i;
          A_MCYCLE:   if (HAS_COUNTERS) mcycle_q <= csr_w_data_i;
          A_MINSTRET: if (HAS_COUNTERS) minstret_q <= csr_w_data_i;
          default:    ;
        endcase
      end
    end
  end

endmodule
